// File: rtl/geriatrics_alu.sv
// Registered 8/16-bit ALU for the Geriatrics 8-bit CPU datapath.
// One-cycle latency, no handshake: every rising clk captures a fresh op.
module geriatrics_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        Cin,
    input  logic [3:0]  alu_op,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    output logic [15:0] result,
    output logic [7:0]  flag
);

    localparam logic [3:0] OP_ADD8  = 4'd0;
    localparam logic [3:0] OP_ADC   = 4'd1;
    localparam logic [3:0] OP_ADD16 = 4'd2;
    localparam logic [3:0] OP_SUB8  = 4'd3;
    localparam logic [3:0] OP_SBC   = 4'd4;
    localparam logic [3:0] OP_SUB16 = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_RR    = 4'd10;
    localparam logic [3:0] OP_RL    = 4'd11;
    localparam logic [3:0] OP_RRC   = 4'd12;
    localparam logic [3:0] OP_RLC   = 4'd13;

    logic [15:0] r_result;
    logic [7:0]  r_flag;

    logic        w_cin_add;
    logic        w_bin_sub;
    logic [8:0]  w_add8;
    logic [8:0]  w_sub8;
    logic [16:0] w_add16;
    logic [16:0] w_sub16;
    logic [7:0]  w_res8;
    logic [15:0] w_next_result;
    logic [7:0]  w_next_flag;
    logic        w_s;
    logic        w_z;
    logic        w_pv;
    logic        w_a;
    logic        w_c;
    logic        w_valid;
    logic        w_wide;

    // Carry/borrow-in only participates in ADC and SBC.
    assign w_cin_add = (alu_op == OP_ADC) ? Cin : 1'b0;
    assign w_bin_sub = (alu_op == OP_SBC) ? Cin : 1'b0;

    // Bit 8 of the 9-bit subtract doubles as the borrow (minuend < subtrahend + borrow).
    assign w_add8  = {1'b0, X[7:0]} + {1'b0, Y[7:0]} + {8'd0, w_cin_add};
    assign w_sub8  = {1'b0, X[7:0]} - {1'b0, Y[7:0]} - {8'd0, w_bin_sub};
    assign w_add16 = {1'b0, X} + {1'b0, Y};
    assign w_sub16 = {1'b0, X} - {1'b0, Y};

    always_comb begin
        w_res8  = 8'h00;
        w_pv    = 1'b0;
        w_a     = 1'b0;
        w_c     = 1'b0;
        w_valid = 1'b1;
        w_wide  = 1'b0;
        unique case (alu_op)
            OP_ADD8, OP_ADC: begin
                w_res8 = w_add8[7:0];
                w_c    = w_add8[8];
                w_pv   = (X[7] == Y[7]) && (w_add8[7] != X[7]);
                w_a    = 1'b1;
            end
            OP_ADD16: begin
                w_wide = 1'b1;
                w_c    = w_add16[16];
                w_pv   = (X[15] == Y[15]) && (w_add16[15] != X[15]);
                w_a    = 1'b1;
            end
            OP_SUB8, OP_SBC: begin
                w_res8 = w_sub8[7:0];
                w_c    = w_sub8[8];
                w_pv   = (X[7] != Y[7]) && (w_sub8[7] != X[7]);
            end
            OP_SUB16: begin
                w_wide = 1'b1;
                w_c    = w_sub16[16];
                w_pv   = (X[15] != Y[15]) && (w_sub16[15] != X[15]);
            end
            OP_AND: begin
                w_res8 = X[7:0] & Y[7:0];
                w_pv   = ~^w_res8;
            end
            OP_OR: begin
                w_res8 = X[7:0] | Y[7:0];
                w_pv   = ~^w_res8;
            end
            OP_XOR: begin
                w_res8 = X[7:0] ^ Y[7:0];
                w_pv   = ~^w_res8;
            end
            OP_NOT: w_res8 = ~X[7:0];
            OP_RR: begin
                w_res8 = {Cin, X[7:1]};
                w_c    = X[0];
            end
            OP_RL: begin
                w_res8 = {X[6:0], Cin};
                w_c    = X[7];
            end
            OP_RRC: begin
                w_res8 = {X[0], X[7:1]};
                w_c    = X[0];
            end
            OP_RLC: begin
                w_res8 = {X[6:0], X[7]};
                w_c    = X[7];
            end
            default: w_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_next_result = 16'h0000;
        w_s           = 1'b0;
        w_z           = 1'b0;
        if (w_wide) begin
            w_next_result = (alu_op == OP_ADD16) ? w_add16[15:0] : w_sub16[15:0];
            w_s           = w_next_result[15];
            w_z           = (w_next_result == 16'h0000);
        end else begin
            w_next_result = {8'h00, w_res8};
            w_s           = w_res8[7];
            w_z           = (w_res8 == 8'h00);
        end
        w_next_flag = w_valid ? {w_s, w_z, 3'b000, w_pv, w_a, w_c} : 8'h00;
        if (!w_valid) begin
            w_next_result = 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 16'h0000;
            r_flag   <= 8'h00;
        end else begin
            r_result <= w_next_result;
            r_flag   <= w_next_flag;
        end
    end

    assign result = r_result;
    assign flag   = r_flag;

endmodule

// File: tb/tb_geriatrics_alu.sv
// Bench for geriatrics_alu: directed vector table, reset/latency sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_geriatrics_alu;

  logic        clk;
  logic        rst;
  logic        cin;
  logic [3:0]  alu_op;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] result;
  logic [7:0]  flag;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic [15:0] er;
    logic [7:0]  ef;
  } vec_t;

  vec_t tbl[$];
  logic [23:0] exp_q[$];

  geriatrics_alu dut (
    .clk    (clk),
    .rst    (rst),
    .Cin    (cin),
    .alu_op (alu_op),
    .X      (x),
    .Y      (y),
    .result (result),
    .flag   (flag)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard compare
  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got result=%h flag=%h, expected result=%h flag=%h",
               name, act[23:8], act[7:0], exp[23:8], exp[7:0]);
    end
  endtask

  // driver
  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic c);
    alu_op = op;
    x      = a;
    y      = b;
    cin    = c;
  endtask

  // reference model: flags from plain integer arithmetic on the operand values
  function automatic int to_signed(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic bit even_parity(input int v);
    int ones = 0;
    for (int k = 0; k < 8; k++) ones += (v >> k) & 1;
    return (ones % 2) == 0;
  endfunction

  function automatic logic [23:0] model(input logic [3:0] op, input logic [15:0] xv,
                                        input logic [15:0] yv, input logic c);
    int a, b, xw, yw, full, sfull, r, width, ci;
    bit fc, fv, fa, valid, msb;
    a = int'(xv[7:0]);
    b = int'(yv[7:0]);
    xw = int'(xv);
    yw = int'(yv);
    ci = c ? 1 : 0;
    width = 8; r = 0; fc = 0; fv = 0; fa = 0; valid = 1;
    case (int'(op))
      0, 1: begin
        if (op == 4'd0) ci = 0;
        full  = a + b + ci;
        sfull = to_signed(a, 8) + to_signed(b, 8) + ci;
        r = full % 256; fc = full > 255; fv = (sfull > 127) || (sfull < -128); fa = 1;
      end
      2: begin
        full  = xw + yw;
        sfull = to_signed(xw, 16) + to_signed(yw, 16);
        r = full % 65536; fc = full > 65535; fv = (sfull > 32767) || (sfull < -32768);
        fa = 1; width = 16;
      end
      3, 4: begin
        if (op == 4'd3) ci = 0;
        full  = a - b - ci;
        sfull = to_signed(a, 8) - to_signed(b, 8) - ci;
        r = (full + 512) % 256; fc = a < (b + ci); fv = (sfull > 127) || (sfull < -128);
      end
      5: begin
        sfull = to_signed(xw, 16) - to_signed(yw, 16);
        r = (xw - yw + 65536) % 65536; fc = xw < yw;
        fv = (sfull > 32767) || (sfull < -32768); width = 16;
      end
      6:  begin r = a & b; fv = even_parity(r); end
      7:  begin r = a | b; fv = even_parity(r); end
      8:  begin r = a ^ b; fv = even_parity(r); end
      9:  r = 255 - a;
      10: begin r = ci * 128 + a / 2; fc = (a % 2) == 1; end
      11: begin r = (a * 2) % 256 + ci; fc = a >= 128; end
      12: begin r = (a % 2) * 128 + a / 2; fc = (a % 2) == 1; end
      13: begin r = (a * 2) % 256 + a / 128; fc = a >= 128; end
      default: valid = 0;
    endcase
    if (!valid) return 24'h0;
    msb = (width == 16) ? (r >= 32768) : (r >= 128);
    return {r[15:0], msb, (r == 0), 3'b000, fv, fa, fc};
  endfunction

  function automatic logic [15:0] pick_operand();
    logic [15:0] edges[6];
    edges = '{16'h0000, 16'h00FF, 16'h0080, 16'h007F, 16'hFFFF, 16'h8000};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  initial begin
    logic [23:0] e;
    drive(4'd0, 16'h0, 16'h0, 1'b0);
    rst = 1'b0;
    #1 rst = 1'b1;
    #2 check("reset_async", {result, flag}, 24'h0);
    @(posedge clk); #1;
    check("reset_held", {result, flag}, 24'h0);
    @(negedge clk) rst = 1'b0;

    tbl.push_back('{4'd0,  16'h0025, 16'h0057, 1'b1, 16'h007C, 8'h02});
    tbl.push_back('{4'd1,  16'h0025, 16'h0057, 1'b1, 16'h007D, 8'h02});
    tbl.push_back('{4'd1,  16'h0045, 16'h0057, 1'b0, 16'h009C, 8'h86});
    tbl.push_back('{4'd0,  16'h0045, 16'h00E5, 1'b0, 16'h002A, 8'h03});
    tbl.push_back('{4'd2,  16'h5678, 16'h1245, 1'b1, 16'h68BD, 8'h02});
    tbl.push_back('{4'd5,  16'h5678, 16'h1245, 1'b1, 16'h4433, 8'h00});
    tbl.push_back('{4'd3,  16'h0057, 16'h0025, 1'b1, 16'h0032, 8'h00});
    tbl.push_back('{4'd4,  16'h0057, 16'h0025, 1'b1, 16'h0031, 8'h00});
    tbl.push_back('{4'd4,  16'h0057, 16'h0072, 1'b1, 16'h00E4, 8'h81});
    tbl.push_back('{4'd3,  16'h0057, 16'h0085, 1'b1, 16'h00D2, 8'h85});
    tbl.push_back('{4'd6,  16'h3457, 16'h3276, 1'b0, 16'h0056, 8'h04});
    tbl.push_back('{4'd7,  16'h3457, 16'h3276, 1'b0, 16'h0077, 8'h04});
    tbl.push_back('{4'd8,  16'h3457, 16'h3276, 1'b0, 16'h0021, 8'h04});
    tbl.push_back('{4'd9,  16'h23FF, 16'h3276, 1'b0, 16'h0000, 8'h40});
    tbl.push_back('{4'd10, 16'h0001, 16'h0000, 1'b0, 16'h0000, 8'h41});
    tbl.push_back('{4'd11, 16'h2280, 16'h0000, 1'b1, 16'h0001, 8'h01});
    tbl.push_back('{4'd12, 16'h23E1, 16'h0000, 1'b0, 16'h00F0, 8'h81});
    tbl.push_back('{4'd13, 16'h23E1, 16'h0000, 1'b0, 16'h00C3, 8'h81});
    tbl.push_back('{4'd15, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 8'h00});
    tbl.push_back('{4'd14, 16'h1234, 16'h5678, 1'b1, 16'h0000, 8'h00});
    tbl.push_back('{4'd6,  16'h00F0, 16'h000F, 1'b1, 16'h0000, 8'h44});
    tbl.push_back('{4'd2,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 8'h43});
    tbl.push_back('{4'd5,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 8'h04});
    tbl.push_back('{4'd4,  16'h0000, 16'h00FF, 1'b1, 16'h0000, 8'h41});

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].cin);
      @(posedge clk); #1;
      check($sformatf("vec%0d_op%0d", i, tbl[i].op), {result, flag}, {tbl[i].er, tbl[i].ef});
    end

    // one-cycle latency: output holds the previous op until the next edge
    @(negedge clk) drive(4'd0, 16'h0025, 16'h0057, 1'b1);
    @(posedge clk); #1;
    check("lat_add8", {result, flag}, {16'h007C, 8'h02});
    @(negedge clk) drive(4'd1, 16'h0025, 16'h0057, 1'b1);
    #1 check("lat_hold", {result, flag}, {16'h007C, 8'h02});
    @(posedge clk); #1;
    check("lat_adc", {result, flag}, {16'h007D, 8'h02});

    // reset between edges clears at once, and first edge after release loads current inputs
    @(negedge clk) drive(4'd0, 16'h0025, 16'h0057, 1'b1);
    @(posedge clk); #1;
    check("pre_reset", {result, flag}, {16'h007C, 8'h02});
    #2 rst = 1'b1;
    #1 check("mid_reset_async", {result, flag}, 24'h0);
    @(posedge clk); #1;
    check("mid_reset_held", {result, flag}, 24'h0);
    @(negedge clk) rst = 1'b0;
    #1 check("post_release_idle", {result, flag}, 24'h0);
    @(posedge clk); #1;
    check("post_release_first", {result, flag}, {16'h007C, 8'h02});

    // randomized ops against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [15:0] a, b;
      logic        c;
      op = 4'($urandom_range(0, 15));
      a  = pick_operand();
      b  = pick_operand();
      c  = 1'($urandom_range(0, 1));
      @(negedge clk);
      drive(op, a, b, c);
      exp_q.push_back(model(op, a, b, c));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check($sformatf("rand%0d_op%0d_x%h_y%h_c%0d", i, op, a, b, c), {result, flag}, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
